// File: rtl/counter_ctrl_seq_if.sv
// Button and control bundle between the board buttons, the control sequencer
// and the counter FSM.
//   btn_mode, btn_dir, btn_hold : raw asynchronous pushbuttons
//   up, even, odd, hold         : registered counter control vector
//   step                        : one-cycle advance strobe for the counter FSM
//   mode                        : parity state (00 ALL, 01 EVEN, 10 ODD)
// The master drives the buttons and observes the controls. The slave is the
// sequencer.
interface counter_ctrl_seq_if;
  logic       btn_mode;
  logic       btn_dir;
  logic       btn_hold;
  logic       up;
  logic       even;
  logic       odd;
  logic       hold;
  logic       step;
  logic [1:0] mode;

  modport master (
    output btn_mode, btn_dir, btn_hold,
    input  up, even, odd, hold, step, mode
  );

  modport slave (
    input  btn_mode, btn_dir, btn_hold,
    output up, even, odd, hold, step, mode
  );
endinterface

// File: rtl/counter_ctrl_seq.sv
// Control sequencer for the display counter.
// It conditions three raw pushbuttons into press pulses. The pulses drive the
// parity-mode FSM, the direction toggle and the hold toggle. It also generates
// the counter's step strobe on the system clock.
// Ports:
//   clk      : system clock, the only clock
//   reset_n  : synchronous active-low reset
//   bus      : counter_ctrl_seq_if.slave
//              (buttons in; up/even/odd/hold/step/mode out)
module counter_ctrl_seq #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 26
) (
  input  logic                 clk,
  input  logic                 reset_n,
  counter_ctrl_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    MODE_ALL  = 2'b00,
    MODE_EVEN = 2'b01,
    MODE_ODD  = 2'b10
  } mode_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_ALL:  next_mode = MODE_EVEN;
      MODE_EVEN: next_mode = MODE_ODD;
      default:   next_mode = MODE_ALL;
    endcase
  endfunction

  // Button index: 0 = mode, 1 = dir, 2 = hold.
  logic [2:0]       raw_btn;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [2:0]       db_lvl;
  logic [2:0]       db_lvl_q;
  logic [CNT_W-1:0] db_cnt [3];
  logic [2:0]       press;

  mode_t            mode_q;
  logic             up_q;
  logic             even_q;
  logic             odd_q;
  logic             hold_q;

  logic [CNT_W-1:0] tick_cnt;
  logic             step_q;
  logic             tick_restart;

  assign raw_btn = {bus.btn_hold, bus.btn_dir, bus.btn_mode};

  // Stage p0/p1: two-flop synchronizer, then per-button stability counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_lvl   <= '0;
      db_lvl_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_p0  <= raw_btn;
      sync_p1  <= sync_p0;
      db_lvl_q <= db_lvl;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Only a debounced rising edge is a press. A release is ignored.
  assign press = db_lvl & ~db_lvl_q;

  // Stage p2: control state, all outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q <= MODE_ALL;
      up_q   <= 1'b1;
      even_q <= 1'b0;
      odd_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      if (press[0]) begin
        mode_q <= next_mode(mode_q);
        even_q <= (next_mode(mode_q) == MODE_EVEN);
        odd_q  <= (next_mode(mode_q) == MODE_ODD);
      end
      if (press[1]) begin
        up_q <= ~up_q;
      end
      if (press[2]) begin
        hold_q <= ~hold_q;
      end
    end
  end

  // Any control change restarts the step period, and so does being held.
  // A step therefore never lands on the same edge as a control update, and
  // the first step after a change comes a full period later.
  assign tick_restart = (|press) | hold_q;

  // Stage p2: step-period counter and registered step strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      step_q   <= 1'b0;
    end else if (tick_restart) begin
      tick_cnt <= '0;
      step_q   <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      step_q   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
      step_q   <= 1'b0;
    end
  end

  assign bus.up   = up_q;
  assign bus.even = even_q;
  assign bus.odd  = odd_q;
  assign bus.hold = hold_q;
  assign bus.step = step_q;
  assign bus.mode = mode_q;

endmodule

// File: tb/tb_counter_ctrl_seq.sv
// Bench for counter_ctrl_seq with TICK_DIV = 8 and DB_CYCLES = 4.
// The bench has three parts: a table of button vectors, hand-written
// sequences for the step-timing corners, and randomized buttons checked
// against a behavioural model.
module tb_counter_ctrl_seq;
  localparam int TICK_DIV  = 8;
  localparam int DB_CYCLES = 4;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic reset_n;

  counter_ctrl_seq_if bus ();

  counter_ctrl_seq #(
    .TICK_DIV (TICK_DIV),
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Behavioural reference model.
  // The buttons are delayed two edges by the synchronizer. A level is
  // accepted once it has differed from the accepted level for DB_CYCLES
  // consecutive edges. An accepted rising level acts one edge later.
  // Steps fall on every TICK_DIV-th edge since the last restart point
  // (reset, a control change, or an edge while held).
  bit m_sp0 [3];
  bit m_sp1 [3];
  bit m_db  [3];
  int m_run [3];
  bit m_pend[3];
  bit m_up, m_hold, m_step;
  int m_mode;
  int m_since;

  task automatic model_step();
    bit raw [3];
    bit evt;
    raw[0] = bus.btn_mode;
    raw[1] = bus.btn_dir;
    raw[2] = bus.btn_hold;
    if (!reset_n) begin
      for (int b = 0; b < 3; b++) begin
        m_sp0[b] = 0; m_sp1[b] = 0; m_db[b] = 0; m_run[b] = 0; m_pend[b] = 0;
      end
      m_up = 1; m_hold = 0; m_step = 0; m_mode = 0; m_since = 0;
    end else begin
      evt = m_pend[0] | m_pend[1] | m_pend[2];
      if (evt || m_hold) begin
        m_since = 0;
        m_step  = 0;
      end else begin
        m_since++;
        m_step = (m_since % TICK_DIV == 0);
      end
      if (m_pend[0]) m_mode = (m_mode + 1) % 3;
      if (m_pend[1]) m_up = !m_up;
      if (m_pend[2]) m_hold = !m_hold;
      for (int b = 0; b < 3; b++) begin
        m_pend[b] = 0;
        if (m_sp1[b] != m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == DB_CYCLES) begin
            m_db[b]   = m_sp1[b];
            m_run[b]  = 0;
            m_pend[b] = m_sp1[b];
          end
        end else begin
          m_run[b] = 0;
        end
        m_sp1[b] = m_sp0[b];
        m_sp0[b] = raw[b];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst_n;
    logic       bm, bd, bh;
    int         cycles;
    logic       e_up;
    logic [1:0] e_mode;
    logic       e_hold;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic bm, input logic bd,
                              input logic bh, input int c, input logic u,
                              input logic [1:0] m, input logic h);
    vec_t v;
    v.rst_n = r; v.bm = bm; v.bd = bd; v.bh = bh; v.cycles = c;
    v.e_up = u; v.e_mode = m; v.e_hold = h;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, k, steps;

    reset_n      = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_dir  = 1'b0;
    bus.btn_hold = 1'b0;

    vecs[0]  = mk(0, 0, 0, 0,  2, 1, 2'b00, 0);
    vecs[1]  = mk(1, 0, 0, 0,  5, 1, 2'b00, 0);
    vecs[2]  = mk(1, 1, 0, 0, 10, 1, 2'b01, 0);
    vecs[3]  = mk(1, 0, 0, 0, 10, 1, 2'b01, 0);
    vecs[4]  = mk(1, 1, 0, 0, 10, 1, 2'b10, 0);
    vecs[5]  = mk(1, 0, 0, 0, 10, 1, 2'b10, 0);
    vecs[6]  = mk(1, 1, 0, 0, 10, 1, 2'b00, 0);
    vecs[7]  = mk(1, 0, 0, 0, 10, 1, 2'b00, 0);
    vecs[8]  = mk(1, 0, 1, 0,  1, 1, 2'b00, 0);
    vecs[9]  = mk(1, 0, 0, 0,  1, 1, 2'b00, 0);
    vecs[10] = mk(1, 0, 1, 0,  1, 1, 2'b00, 0);
    vecs[11] = mk(1, 0, 0, 0, 10, 1, 2'b00, 0);
    vecs[12] = mk(1, 0, 1, 0,  6, 1, 2'b00, 0);
    vecs[13] = mk(1, 0, 0, 0,  6, 0, 2'b00, 0);
    vecs[14] = mk(1, 0, 0, 1, 10, 0, 2'b00, 1);
    vecs[15] = mk(1, 0, 0, 0, 10, 0, 2'b00, 1);

    for (int i = 0; i < 16; i++) begin
      reset_n      = vecs[i].rst_n;
      bus.btn_mode = vecs[i].bm;
      bus.btn_dir  = vecs[i].bd;
      bus.btn_hold = vecs[i].bh;
      repeat (vecs[i].cycles) tick();
      check_bit($sformatf("vec%0d_up", i), bus.up, vecs[i].e_up);
      check_int($sformatf("vec%0d_mode", i), int'(bus.mode), int'(vecs[i].e_mode));
      check_bit($sformatf("vec%0d_hold", i), bus.hold, vecs[i].e_hold);
      check_bit($sformatf("vec%0d_even", i), bus.even, vecs[i].e_mode == 2'b01);
      check_bit($sformatf("vec%0d_odd", i), bus.odd, vecs[i].e_mode == 2'b10);
    end

    // Reset, then the idle step cadence
    bus.btn_mode = 0; bus.btn_dir = 0; bus.btn_hold = 0;
    reset_n = 0;
    tick();
    check_bit("rst_up", bus.up, 1'b1);
    check_int("rst_mode", int'(bus.mode), 0);
    check_bit("rst_hold", bus.hold, 1'b0);
    check_bit("rst_step", bus.step, 1'b0);
    reset_n = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      check_bit($sformatf("idle_step_c%0d", i), bus.step, (i % TICK_DIV == 0));
    end

    // A mode press lands 7 cycles after the raw edge; the next step is 8 later
    bus.btn_mode = 1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) check_int("mode_before_latency", int'(bus.mode), 0);
    end
    check_int("mode_after_latency", int'(bus.mode), 1);
    check_bit("mode_even", bus.even, 1'b1);
    check_bit("mode_change_no_step", bus.step, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 3) bus.btn_mode = 0;
      check_bit($sformatf("mode_next_step_j%0d", j), bus.step, (j == 8));
    end

    // Hold suppresses steps; after release the first step is 8 cycles later
    bus.btn_hold = 1;
    repeat (7) tick();
    check_bit("hold_set", bus.hold, 1'b1);
    bus.btn_hold = 0;
    steps = 0;
    repeat (50) begin
      tick();
      if (bus.step) steps++;
    end
    check_int("hold_steps_while_held", steps, 0);
    check_bit("hold_still_set", bus.hold, 1'b1);
    bus.btn_hold = 1;
    n = 0;
    while (bus.hold && n < 20) begin
      tick();
      n++;
    end
    check_int("hold_release_latency", n, 7);
    bus.btn_hold = 0;
    k = 0;
    while (!bus.step && k < 20) begin
      tick();
      k++;
    end
    check_int("hold_first_step_delay", k, TICK_DIV);

    // Mode and dir accepted together on the terminal-count edge
    tick();
    bus.btn_mode = 1;
    bus.btn_dir  = 1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_bit($sformatf("coinc_no_step_i%0d", i), bus.step, 1'b0);
    end
    check_int("coinc_mode", int'(bus.mode), 2);
    check_bit("coinc_up", bus.up, 1'b0);
    check_bit("coinc_odd", bus.odd, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 3) begin
        bus.btn_mode = 0;
        bus.btn_dir  = 0;
      end
      check_bit($sformatf("coinc_next_step_j%0d", j), bus.step, (j == 8));
    end

    // Reset mid-debounce while held in ODD
    bus.btn_hold = 1;
    repeat (10) tick();
    bus.btn_hold = 0;
    repeat (10) tick();
    check_bit("prerst_hold", bus.hold, 1'b1);
    check_int("prerst_mode", int'(bus.mode), 2);
    bus.btn_mode = 1;
    repeat (4) tick();
    reset_n = 0;
    bus.btn_mode = 0;
    tick();
    check_bit("midrst_up", bus.up, 1'b1);
    check_int("midrst_mode", int'(bus.mode), 0);
    check_bit("midrst_hold", bus.hold, 1'b0);
    check_bit("midrst_odd", bus.odd, 1'b0);
    check_bit("midrst_step", bus.step, 1'b0);
    reset_n = 1;
    repeat (15) tick();
    check_int("postrst_mode", int'(bus.mode), 0);
    check_bit("postrst_even", bus.even, 1'b0);
    check_bit("postrst_hold", bus.hold, 1'b0);
    check_bit("postrst_up", bus.up, 1'b1);

    // Randomized buttons against the model
    reset_n = 0;
    tick();
    reset_n = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) bus.btn_mode = ~bus.btn_mode;
      if ($urandom_range(0, 5) == 0) bus.btn_dir  = ~bus.btn_dir;
      if ($urandom_range(0, 5) == 0) bus.btn_hold = ~bus.btn_hold;
      reset_n = ($urandom_range(0, 999) != 0);
      tick();
      check_bit($sformatf("rnd%0d_up", c), bus.up, m_up);
      check_bit($sformatf("rnd%0d_hold", c), bus.hold, m_hold);
      check_bit($sformatf("rnd%0d_step", c), bus.step, m_step);
      check_int($sformatf("rnd%0d_mode", c), int'(bus.mode), m_mode);
      check_bit($sformatf("rnd%0d_even", c), bus.even, m_mode == 1);
      check_bit($sformatf("rnd%0d_odd", c), bus.odd, m_mode == 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
